// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - Simon32/64 widths, z0 constant, controller state type and round helpers
package simon_pkg;

  localparam int WORD_W  = 16;
  localparam int BLOCK_W = 32;
  localparam int KEY_W   = 64;

  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [WORD_W-1:0] simon_f(input logic [WORD_W-1:0] x);
    return ({x[14:0], x[15]} & {x[7:0], x[15:8]}) ^ {x[13:0], x[15:14]};
  endfunction

  // Next key word from the four-word window; k2 does not take part for m=4.
  function automatic logic [WORD_W-1:0] simon_key_next(input logic [WORD_W-1:0] k0,
                                                       input logic [WORD_W-1:0] k1,
                                                       input logic [WORD_W-1:0] k3,
                                                       input logic              zbit);
    logic [WORD_W-1:0] t;
    t = {k3[2:0], k3[15:3]} ^ k1;
    t = t ^ {t[0], t[15:1]};
    return ~k0 ^ t ^ {{(WORD_W-1){1'b0}}, zbit} ^ 16'h0003;
  endfunction

endpackage

// File: rtl/simon_round.sv
// rtl/simon_round.sv - combinational Simon32/64 round plus one key-schedule step
// key_next is the shifted key window {knew, k3, k2, k1}; knew sits in its top word.
module simon_round
  import simon_pkg::*;
(
  input  logic [WORD_W-1:0] x,
  input  logic [WORD_W-1:0] y,
  input  logic [WORD_W-1:0] k0,
  input  logic [WORD_W-1:0] k1,
  input  logic [WORD_W-1:0] k2,
  input  logic [WORD_W-1:0] k3,
  input  logic              zbit,
  output logic [WORD_W-1:0] x_next,
  output logic [WORD_W-1:0] y_next,
  output logic [KEY_W-1:0]  key_next
);

  logic [WORD_W-1:0] knew;

  assign x_next   = y ^ simon_f(x) ^ k0;
  assign y_next   = x;
  assign knew     = simon_key_next(k0, k1, k3, zbit);
  assign key_next = {knew, k3, k2, k1};

endmodule

// File: rtl/simon_iter_ctrl.sv
// rtl/simon_iter_ctrl.sv - iterative Simon32/64 encryption controller, one round per clock
// Optional abort input enabled by defining SIMON_ABORT_EN.
module simon_iter_ctrl
  import simon_pkg::*;
#(
  parameter int ROUNDS = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] plaintext,
  input  logic [KEY_W-1:0]   key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] ciphertext
`ifdef SIMON_ABORT_EN
  ,
  input  logic               abort
`endif
);

  localparam logic [4:0] LAST = 5'(ROUNDS - 1);

  state_t             state;
  logic [WORD_W-1:0]  x, y;
  logic [KEY_W-1:0]   kreg;
  logic [4:0]         rnd;
  logic [WORD_W-1:0]  x_next, y_next;
  logic [KEY_W-1:0]   key_next;
  logic               zbit;
  logic               accept;
  logic               abort_hit;

  // DONE can hand off and accept on the same edge, so the ready path sees out_ready.
  assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept   = in_valid & in_ready;
  assign zbit     = Z0[6'd61 - {1'b0, rnd}];

`ifdef SIMON_ABORT_EN
  assign abort_hit = abort & (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  simon_round u_round (
    .x        (x),
    .y        (y),
    .k0       (kreg[15:0]),
    .k1       (kreg[31:16]),
    .k2       (kreg[47:32]),
    .k3       (kreg[63:48]),
    .zbit     (zbit),
    .x_next   (x_next),
    .y_next   (y_next),
    .key_next (key_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      ciphertext <= '0;
      rnd        <= '0;
      x          <= '0;
      y          <= '0;
      kreg       <= '0;
    end else if (abort_hit) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else if (accept) begin
      state     <= RUN;
      out_valid <= 1'b0;
      x         <= plaintext[31:16];
      y         <= plaintext[15:0];
      kreg      <= key;
      rnd       <= '0;
    end else begin
      case (state)
        RUN: begin
          x    <= x_next;
          y    <= y_next;
          kreg <= key_next;
          rnd  <= rnd + 5'd1;
          if (rnd == LAST) begin
            state      <= DONE;
            out_valid  <= 1'b1;
            ciphertext <= {x_next, y_next};
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_iter_ctrl.sv
// tb/tb_simon_iter_ctrl.sv - scoreboard bench for simon_iter_ctrl (32-round and 1-round instances)
module tb_simon_iter_ctrl;

  localparam logic [61:0] ZC = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [63:0] KAT_KEY = 64'h1918_1110_0908_0100;
  localparam logic [31:0] KAT_PT  = 32'h6565_6877;
  localparam logic [31:0] KAT_CT  = 32'hc69b_e9bb;

  typedef struct {
    logic [31:0] ct;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid;
  logic [31:0] plaintext, ciphertext;
  logic [63:0] key;
  logic        or_fix, or_rand, rand_bp;
  logic        out_ready;
  logic        iv1, ir1, ov1;
  logic        or1 = 1'b1;
  logic [31:0] pt1, ct1;
  logic [63:0] key1;
`ifdef SIMON_ABORT_EN
  logic        abort, abort1;
`endif

  int   tests = 0, fails = 0, cyc = 0, last_hs = -1;
  exp_t q[$], q1[$];
  logic ov_q = 1'b0, ov1_q = 1'b0;

  assign out_ready = rand_bp ? or_rand : or_fix;

  simon_iter_ctrl #(.ROUNDS(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .plaintext(plaintext), .key(key), .out_valid(out_valid), .out_ready(out_ready),
    .ciphertext(ciphertext)
`ifdef SIMON_ABORT_EN
    , .abort(abort)
`endif
  );

  simon_iter_ctrl #(.ROUNDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
    .plaintext(pt1), .key(key1), .out_valid(ov1), .out_ready(or1),
    .ciphertext(ct1)
`ifdef SIMON_ABORT_EN
    , .abort(abort1)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;
  always @(posedge clk) begin
    #1;
    or_rand = 1'($urandom_range(0, 1));
  end

  function automatic logic [15:0] rol(input logic [15:0] v, input int n);
    return (v << n) | (v >> (16 - n));
  endfunction

  function automatic logic [15:0] ror(input logic [15:0] v, input int n);
    return (v >> n) | (v << (16 - n));
  endfunction

  // Textbook Simon32/64: expand the whole key schedule, then run the Feistel rounds.
  function automatic logic [31:0] simon_ref(input logic [31:0] p, input logic [63:0] k, input int rounds);
    logic [15:0] ks[0:31];
    logic [15:0] xx, yy, t;
    logic [61:0] z;
    z = ZC;
    for (int i = 0; i < 4; i++) ks[i] = k[16*i +: 16];
    for (int i = 4; i < rounds; i++) begin
      t = ror(ks[i-1], 3) ^ ks[i-3];
      t = t ^ ror(t, 1);
      ks[i] = ~ks[i-4] ^ t ^ {15'd0, z[61-(i-4)]} ^ 16'h0003;
    end
    xx = p[31:16];
    yy = p[15:0];
    for (int r = 0; r < rounds; r++) begin
      t  = xx;
      xx = yy ^ ((rol(xx, 1) & rol(xx, 8)) ^ rol(xx, 2)) ^ ks[r];
      yy = t;
    end
    return {xx, yy};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset();
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_ciphertext", 64'(ciphertext), 64'd0);
  endtask

  task automatic send(input logic [31:0] p, input logic [63:0] k, input logic [31:0] exp_ct, output int acc);
    int n;
    n = 0;
    acc = -1;
    plaintext = p;
    key = k;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 64'(in_ready), 64'd1);
    if (in_ready) begin
      acc = cyc + 1;
      q.push_back('{ct: exp_ct, acc: acc});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send1(input logic [31:0] p, input logic [63:0] k, input logic [31:0] exp_ct);
    int n;
    n = 0;
    pt1 = p;
    key1 = k;
    iv1 = 1'b1;
    @(negedge clk);
    while (!ir1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait_r1", 64'(ir1), 64'd1);
    if (ir1) q1.push_back('{ct: exp_ct, acc: cyc + 1});
    @(posedge clk);
    #1;
    iv1 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  task automatic drain1();
    int n;
    n = 0;
    while (q1.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_r1", 64'(q1.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && q.size() == 0) chk("spurious_out_valid", 64'(out_valid), 64'd0);
      else if (out_valid && !ov_q) chk("latency", 64'(cyc - q[0].acc), 64'd32);
      if (out_valid && q.size() != 0) begin
        if (out_ready) begin
          chk("ct", 64'(ciphertext), 64'(q[0].ct));
          last_hs = cyc + 1;
          void'(q.pop_front());
        end else begin
          chk("ct_hold", 64'(ciphertext), 64'(q[0].ct));
          chk("in_ready_busy", 64'(in_ready), 64'd0);
        end
      end
    end
    ov_q = out_valid;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (ov1 && q1.size() == 0) chk("spurious_out_valid_r1", 64'(ov1), 64'd0);
      else if (ov1 && !ov1_q) chk("latency_r1", 64'(cyc - q1[0].acc), 64'd1);
      if (ov1 && q1.size() != 0) begin
        chk("ct_r1", 64'(ct1), 64'(q1[0].ct));
        void'(q1.pop_front());
      end
    end
    ov1_q = ov1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc_a, acc_b, n;
    logic [31:0] p;
    logic [63:0] k;
    rst_n = 1'b0;
    in_valid = 1'b0; plaintext = '0; key = '0;
    iv1 = 1'b0; pt1 = '0; key1 = '0;
    or_fix = 1'b1; rand_bp = 1'b0;
`ifdef SIMON_ABORT_EN
    abort = 1'b0; abort1 = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(KAT_PT, KAT_KEY, KAT_CT, acc_a);
    drain();

    send1(KAT_PT, KAT_KEY, 32'hBCA2_6565);
    for (int i = 0; i < 5; i++) begin
      p = $urandom;
      k = {$urandom, $urandom};
      send1(p, k, simon_ref(p, k, 1));
    end
    drain1();

    or_fix = 1'b0;
    send(KAT_PT, KAT_KEY, KAT_CT, acc_a);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    or_fix = 1'b1;
    drain();

    p = $urandom; k = {$urandom, $urandom};
    send(p, k, simon_ref(p, k, 32), acc_a);
    p = $urandom; k = {$urandom, $urandom};
    send(p, k, simon_ref(p, k, 32), acc_b);
    chk("b2b_same_edge", 64'(acc_b), 64'(last_hs));
    drain();

    rand_bp = 1'b1;
    for (int i = 0; i < 6; i++) begin
      p = $urandom; k = {$urandom, $urandom};
      send(p, k, simon_ref(p, k, 32), acc_a);
    end
    drain();
    rand_bp = 1'b0;

    p = $urandom; k = {$urandom, $urandom};
    send(p, k, simon_ref(p, k, 32), acc_a);
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b1; plaintext = $urandom; key = {$urandom, $urandom};
    @(negedge clk);
    chk("busy_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    q.delete();
    chk_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    send(KAT_PT, KAT_KEY, KAT_CT, acc_a);
    drain();

`ifdef SIMON_ABORT_EN
    p = $urandom; k = {$urandom, $urandom};
    send(p, k, simon_ref(p, k, 32), acc_a);
    repeat (4) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    q.delete();
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_ct_kept", 64'(ciphertext), 64'(KAT_CT));
    repeat (40) @(posedge clk);
    #1;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
